// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared constants and FSM state type for the number renderer
package render_pkg;
  localparam int DIGIT_W           = 12;
  localparam int DIGIT_H           = 18;
  localparam int RENDER_MIN_CYCLES = 4 * DIGIT_W * DIGIT_H;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONVERT,
    ST_DRAW,
    ST_DONE
  } rn_state_t;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle double-dabble binary to BCD converter
module bin2bcd_seq #(
  parameter int VAL_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VAL_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    shift;
  logic [CNT_W-1:0]    iter;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign valid = (iter == CNT_W'(VAL_W));

  // The counter parks at VAL_W so the result stays stable until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd   <= '0;
      shift <= '0;
      iter  <= CNT_W'(VAL_W);
    end else if (load) begin
      bcd   <= '0;
      shift <= bin;
      iter  <= '0;
    end else if (!valid) begin
      {bcd, shift} <= {adj, shift} << 1;
      iter         <= iter + 1'b1;
    end
  end
endmodule

// File: rtl/render_number.sv
// rtl/render_number.sv - right-aligned decimal renderer feeding the single-digit renderer
module render_number #(
  parameter int DIGITS       = 5,
  parameter int VAL_W        = 17,
  parameter int DIGIT_W      = 12,
  parameter int DIGIT_CYCLES = 1024,
  parameter int LZ_BLANK     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  input  logic [9:0]       top,
  input  logic [9:0]       left,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit,
  output logic [9:0]       digit_top,
  output logic [9:0]       digit_left,
  output logic             digit_start
);
  import render_pkg::*;

  localparam int     IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int     WIN_W   = $clog2(DIGIT_CYCLES);
  localparam longint MAX_VAL = pow10(DIGITS) - 1;

  rn_state_t             state;
  logic [9:0]            top_q, left_q;
  logic                  accept, over_in;
  logic [VAL_W-1:0]      value_sat;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic [IDX_W-1:0]      idx, first_idx, sel_idx;
  logic [WIN_W-1:0]      win;
  logic [3:0]            digit_nxt;
  logic [9:0]            left_nxt;

  assign accept    = (state == ST_IDLE) && start;
  assign over_in   = 64'(value) > 64'(MAX_VAL);
  assign value_sat = over_in ? VAL_W'(MAX_VAL) : value;

  // Conversion starts on the accept edge so the BCD result is ready as CONVERT ends.
  bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .bin   (value_sat),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  always_comb begin
    first_idx = IDX_W'(DIGITS - 1);
    if (LZ_BLANK == 0) begin
      first_idx = '0;
    end else begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (bcd[4*(DIGITS-1-i) +: 4] != 4'd0) first_idx = IDX_W'(i);
      end
    end
  end

  assign sel_idx   = (state == ST_DRAW) ? idx + 1'b1 : first_idx;
  assign digit_nxt = bcd[4*(DIGITS-1-int'(sel_idx)) +: 4];
  assign left_nxt  = left_q + 10'(int'(sel_idx) * DIGIT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      digit       <= '0;
      digit_top   <= '0;
      digit_left  <= '0;
      digit_start <= 1'b0;
      idx         <= '0;
      win         <= '0;
      top_q       <= '0;
      left_q      <= '0;
    end else begin
      done        <= 1'b0;
      digit_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            top_q    <= top;
            left_q   <= left;
            overflow <= over_in;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_CONVERT;
        ST_CONVERT: begin
          if (bcd_valid) begin
            idx         <= first_idx;
            win         <= '0;
            digit_start <= 1'b1;
            digit       <= digit_nxt;
            digit_top   <= top_q;
            digit_left  <= left_nxt;
            state       <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (win == WIN_W'(DIGIT_CYCLES - 1)) begin
            if (idx == IDX_W'(DIGITS - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx         <= idx + 1'b1;
              win         <= '0;
              digit_start <= 1'b1;
              digit       <= digit_nxt;
              digit_top   <= top_q;
              digit_left  <= left_nxt;
            end
          end else begin
            win <= win + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_render_number.sv
// tb/tb_render_number.sv - directed self-checking bench for render_number
module tb_render_number;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        nz_sel = 1'b0;
  logic [16:0] value = '0;
  logic [9:0]  top = '0, left = '0;

  logic       busy_a, done_a, ovf_a, ds_a, busy_b, done_b, ovf_b, ds_b;
  logic [3:0] dig_a, dig_b;
  logic [9:0] dt_a, dl_a, dt_b, dl_b;
  logic       busy, done, ovf, ds;
  logic [3:0] dig;
  logic [9:0] dt, dl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  render_number #(.LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .start(start && !nz_sel), .value(value), .top(top), .left(left),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .digit(dig_a),
    .digit_top(dt_a), .digit_left(dl_a), .digit_start(ds_a)
  );

  render_number #(.LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .start(start && nz_sel), .value(value), .top(top), .left(left),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .digit(dig_b),
    .digit_top(dt_b), .digit_left(dl_b), .digit_start(ds_b)
  );

  always_comb begin
    busy = nz_sel ? busy_b : busy_a;
    done = nz_sel ? done_b : done_a;
    ovf  = nz_sel ? ovf_b  : ovf_a;
    ds   = nz_sel ? ds_b   : ds_a;
    dig  = nz_sel ? dig_b  : dig_a;
    dt   = nz_sel ? dt_b   : dt_a;
    dl   = nz_sel ? dl_b   : dl_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_dstart"}, 32'(ds), 0);
    check({tag, "_digit"}, 32'(dig), 0);
    check({tag, "_dtop"}, 32'(dt), 0);
    check({tag, "_dleft"}, 32'(dl), 0);
  endtask

  // exp_bcd holds the five expected digits, most significant nibble first.
  task automatic run(input string tag, input logic [16:0] v, input logic [9:0] l,
                     input logic [9:0] t, input int first, input logic [19:0] exp_bcd,
                     input logic exp_ovf, input bit poke);
    int n, last, k, i, ds_bad, busy_bad, early_done, hold_bad;
    logic exp_ds;
    logic [3:0] exp_dig;
    logic [9:0] exp_left;
    n = 5 - first;
    last = 19 + n * 1024;
    ds_bad = 0; busy_bad = 0; early_done = 0; hold_bad = 0;
    @(negedge clk);
    start = 1'b1; value = v; left = l; top = t;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    for (int c = 1; c <= last; c++) begin
      exp_ds = (c >= 19) && (c < last) && ((c - 19) % 1024 == 0);
      if (ds !== exp_ds) ds_bad++;
      if (busy !== (c < last)) busy_bad++;
      if (c < last && done !== 1'b0) early_done++;
      if (c >= 19 && c < last) begin
        k = (c - 19) / 1024;
        i = first + k;
        exp_dig  = exp_bcd[4*(4-i) +: 4];
        exp_left = 10'(int'(l) + i * 12);
        if (dig !== exp_dig || dl !== exp_left || dt !== t) hold_bad++;
        if (exp_ds) begin
          check($sformatf("%s_digit%0d", tag, k), 32'(dig), 32'(exp_dig));
          check($sformatf("%s_left%0d", tag, k), 32'(dl), 32'(exp_left));
          check($sformatf("%s_top%0d", tag, k), 32'(dt), 32'(t));
        end
      end
      if (c == last) begin
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_fall"}, 32'(busy), 0);
        check({tag, "_ovf_end"}, 32'(ovf), 32'(exp_ovf));
      end
      if (poke && (c == 5 || c == 19 + 2 * 1024 + 100)) begin
        start = 1'b1; value = 17'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_dstart_pattern"}, 32'(ds_bad), 0);
    check({tag, "_busy_pattern"}, 32'(busy_bad), 0);
    check({tag, "_no_early_done"}, 32'(early_done), 0);
    check({tag, "_hold"}, 32'(hold_bad), 0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run("v12345", 17'd12345, 10'd100, 10'd50, 0, 20'h12345, 1'b0, 1'b0);
    run("v42", 17'd42, 10'd200, 10'd7, 3, 20'h00042, 1'b0, 1'b0);
    run("v0", 17'd0, 10'd1000, 10'd3, 4, 20'h00000, 1'b0, 1'b0);
    run("v131071", 17'd131071, 10'd20, 10'd30, 0, 20'h99999, 1'b1, 1'b0);
    run("v7", 17'd7, 10'd0, 10'd0, 4, 20'h00007, 1'b0, 1'b0);
    run("poke", 17'd12345, 10'd100, 10'd50, 0, 20'h12345, 1'b0, 1'b1);

    nz_sel = 1'b1;
    run("nz0", 17'd0, 10'd10, 10'd20, 0, 20'h00000, 1'b0, 1'b0);
    nz_sel = 1'b0;

    // Reset in the middle of the second window (digit 2).
    @(negedge clk);
    start = 1'b1; value = 17'd12345; left = 10'd100; top = 10'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (19 + 1024 + 500 - 1) @(negedge clk);
    check("mid_digit", 32'(dig), 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_state", 32'(dut_a.state), 32'(ST_IDLE));
    rst = 1'b0;
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 0);
    run("after_rst", 17'd12345, 10'd100, 10'd50, 0, 20'h12345, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
